// File: rtl/fifo_wr_arbiter_if.sv
// Producer/consumer/FIFO-status bundle for fifo_wr_arbiter.
// FIFO_WR_ARBITER_STATS_EN adds the wr_count/stall_count statistics signals.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            gnt;
  logic                          rd_req;
  logic                          rd_ack;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_rd;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_threshold;
  logic                          fifo_overflow;
  logic                          fifo_underflow;
  logic                          err_ovf;
  logic                          err_udf;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0]                   wr_count;
  logic [15:0]                   stall_count;
`endif

  modport master (
`ifdef FIFO_WR_ARBITER_STATS_EN
    input  wr_count, stall_count,
`endif
    output req, req_data, rd_req,
    output fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow,
    input  ack, gnt, rd_ack, fifo_wr, fifo_wdata, fifo_rd, err_ovf, err_udf
  );

  modport slave (
`ifdef FIFO_WR_ARBITER_STATS_EN
    output wr_count, stall_count,
`endif
    input  req, req_data, rd_req,
    input  fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow,
    output ack, gnt, rd_ack, fifo_wr, fifo_wdata, fifo_rd, err_ovf, err_udf
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the fifo_mem write port, with read gating and sticky FIFO errors.
// FIFO_WR_ARBITER_STATS_EN adds saturating wr_count/stall_count statistics.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.slave    bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_ovf_q, err_udf_q;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  int unsigned        cand;
  logic               cur_req;
  logic               write_ok;
  logic [4:0]         cnt_inc;

  // First requester at or after last_q+1, wrapping; lowest offset wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_vld && bus.req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  assign cur_req  = bus.req[g_q];
  assign write_ok = (state_q == BURST) & cur_req & ~bus.fifo_full & rst_n;
  assign cnt_inc  = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && !bus.fifo_full) begin
          state_d = BURST;
          g_d     = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (write_ok) cnt_d = cnt_q + 4'd1;
        if (!cur_req || (write_ok && ((cnt_inc == 5'(MAX_BURST)) || bus.fifo_threshold))) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = g_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      g_q       <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      g_q       <= g_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_ovf_q <= err_ovf_q | bus.fifo_overflow;
      err_udf_q <= err_udf_q | bus.fifo_underflow;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = write_ok ? gnt_q : '0;
  assign bus.fifo_wr    = write_ok;
  assign bus.fifo_wdata = bus.req_data[g_q*DATA_WIDTH +: DATA_WIDTH];
  // Reads are gated by rst_n so nothing reaches the FIFO while reset is held.
  assign bus.fifo_rd    = bus.rd_req & ~bus.fifo_empty & rst_n;
  assign bus.rd_ack     = bus.rd_req & ~bus.fifo_empty & rst_n;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_udf    = err_udf_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] wr_count_q, stall_count_q;
  logic        stall;

  assign stall = (state_q == BURST) & cur_req & bus.fifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (write_ok && (wr_count_q != '1))    wr_count_q    <= wr_count_q + 16'd1;
      if (stall && (stall_count_q != '1))    stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign bus.wr_count    = wr_count_q;
  assign bus.stall_count = stall_count_q;
`endif
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 8-bit `fifo_mem` buffer among NUM_REQ producers.
- Grants one producer at a time for a bounded burst and shortens bursts when the FIFO reports threshold.
- Stalls on fifo_full. Gates consumer reads against fifo_empty.
- Records sticky overflow/underflow errors reported by the FIFO.
- Sits directly between producer/consumer logic and `fifo_mem`.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, word width; matches the fifo_mem data_in/data_out width.
- MAX_BURST, 4, maximum words per grant (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-producer word valid.
- req_data  in  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot; word from producer i accepted this cycle.
- gnt  out  NUM_REQ  one-hot registered current grant; 0 when idle.
- rd_req  in  1  consumer read request.
- rd_ack  out  1  read issued to FIFO this cycle.
- fifo_wr  out  1  to fifo_mem wr.
- fifo_wdata  out  DATA_WIDTH  to fifo_mem data_in.
- fifo_rd  out  1  to fifo_mem rd.
- fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow  in  1 each  FIFO status.
- err_ovf  out  1  sticky; set by fifo_overflow.
- err_udf  out  1  sticky; set by fifo_underflow.

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - state=IDLE, gnt=0, burst_cnt=0, last_gnt=NUM_REQ-1, err_ovf=0, err_udf=0.
  - The combinational outputs ack, fifo_wr, fifo_rd and rd_ack evaluate to 0 while state is IDLE and rst_n=0.
  - Reset applied mid-burst aborts the burst. No write occurs in the reset cycle.
- State machine, two states:
  - IDLE: if any req is high and fifo_full=0, register gnt to the first requester searching from (last_gnt+1) mod NUM_REQ upward with wrap. Then burst_cnt=0 and state moves to BURST. With no requester, or with fifo_full=1, stay in IDLE.
  - BURST, write cycle: with grant index g, write_ok = req[g] & ~fifo_full. Then fifo_wr = write_ok, ack[g] = write_ok, fifo_wdata = slice g of req_data; all combinational, same cycle.
  - BURST, counting: on write_ok, burst_cnt increments.
  - BURST, exit: return to IDLE, clear gnt and set last_gnt=g when any of these holds:
    - req[g]=0;
    - write_ok and burst_cnt+1 == MAX_BURST;
    - write_ok and fifo_threshold=1 (threshold forces a 1-word burst).
  - BURST, stall: fifo_full=1 with req[g]=1 holds the grant, issues no write and does not advance the count.
- Latency:
  - A request seen in IDLE yields its first accepted word on the next cycle.
  - There is a minimum of 1 idle cycle between bursts.
- Fairness:
  - A requester that has just been served has lowest priority at the next arbitration.
  - A requester asserting continuously waits at most (NUM_REQ-1) bursts.
- Read path, combinational, independent of the FSM:
  - fifo_rd = rd_ack = rd_req & ~fifo_empty.
  - Reads and writes may occur in the same cycle.
- Sticky errors:
  - err_ovf is set on any cycle with fifo_overflow=1; err_udf is set on any cycle with fifo_underflow=1.
  - Both clear only on reset.
  - With correct gating neither should set.
- ack and fifo_wr are never asserted when fifo_full=1. fifo_rd is never asserted when fifo_empty=1.

Optional Feature:
- Macro FIFO_WR_ARBITER_STATS_EN.
- Defined:
  - Adds outputs wr_count[15:0] (total accepted words) and stall_count[15:0] (BURST cycles with req[g]=1 and fifo_full=1).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with req=4'b1111 and rd_req=1 -> gnt=0, ack=0, fifo_wr=0, fifo_rd=0, err_ovf=0, err_udf=0.
- Single producer: req=4'b0001 held, data 8'h11..8'h16, FIFO not full -> gnt=0001 one cycle after request; 4 writes 11,12,13,14; 1 idle cycle; re-grant to producer 0; writes 15,16.
- Round robin: req=4'b1111 held, MAX_BURST=4 -> grant order 0001, 0010, 0100, 1000, 0001; exactly 4 acks per grant.
- Full stall: fifo_full=1 for 3 cycles mid-burst after 2 writes -> no fifo_wr or ack during those cycles, grant held; burst completes 2 more words after fifo_full=0.
- Threshold: fifo_threshold=1, req=4'b0011 -> bursts of exactly 1 word alternating producers 0 and 1.
- Read gating and errors: rd_req=1 with fifo_empty=1 -> fifo_rd=0. Pulse fifo_overflow for 1 cycle -> err_ovf=1 held until rst_n=0.
